dfswt_gen: RTL and testbench

Square-wave excitation generator for the DFSWT chain. Emits a framed stream of signed 16-bit samples of ±amplitude, with a phase counter that runs on the same convention as the DFSWT correlator stages. A stage loaded with the same `step` therefore accumulates a known coherent value. Sits at the head of the simulation/test datapath and drives the stages' `datain`/`enable` through a valid/ready handshake.

---
 rtl/dfswt_pkg.sv | 31 +++
 rtl/dfswt_phase_counter.sv | 52 +++++
 rtl/dfswt_gen.sv | 165 ++++++++++++++++
 tb/tb_dfswt_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dfswt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dfswt_pkg
//  Description : Shared definitions for the DFSWT generator and correlator
//                stages: sample/accumulator widths, the generator FSM state
//                type with its encoded states, and a saturating negate.
//  Revision    : 1.0 - initial release
// ============================================================================
package dfswt_pkg;

  localparam int SAMPLE_W = 16;
  localparam int ACC_W    = 32;

  typedef logic [0:0] dfswt_gen_state_t;

  localparam dfswt_gen_state_t ST_IDLE = 1'b0;
  localparam dfswt_gen_state_t ST_RUN  = 1'b1;

  // Two's-complement negate that clamps the one unrepresentable case
  // (-2^(W-1)) to the largest positive value instead of wrapping.
  function automatic logic signed [SAMPLE_W-1:0] sat_neg(
      input logic signed [SAMPLE_W-1:0] a);
    if (a == {1'b1, {(SAMPLE_W-1){1'b0}}}) begin
      sat_neg = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end else begin
      sat_neg = -a;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/dfswt_phase_counter.sv
`default_nettype none
// ============================================================================
//  Module      : dfswt_phase_counter
//  Description : Modulo-2^COUNTBITS phase accumulator shared by the DFSWT
//                generator and correlator stages. Loads POINTS/4 (quarter
//                period, the common phase origin) and advances by step on
//                enable, wrapping silently.
//  Ports       : clock, reset (async active-low), load, enable, step,
//                msb (current phase MSB), msb_next (MSB after this cycle).
//  Revision    : 1.0 - initial release
// ============================================================================
module dfswt_phase_counter #(
  parameter int POINTS    = 8,
  parameter int COUNTBITS = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 enable,
  input  logic [COUNTBITS-1:0] step,
  output logic                 msb,
  output logic                 msb_next
);

  localparam logic [COUNTBITS-1:0] LOAD_VAL = COUNTBITS'(POINTS / 4);

  logic [COUNTBITS-1:0] phase_q;
  logic [COUNTBITS-1:0] phase_d;

  always_comb begin
    phase_d = phase_q;
    if (load) begin
      phase_d = LOAD_VAL;
    end else if (enable) begin
      phase_d = phase_q + step;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign msb      = phase_q[COUNTBITS-1];
  // The generator registers its sample, so it needs the upcoming phase.
  assign msb_next = phase_d[COUNTBITS-1];

endmodule
`default_nettype wire

// File: rtl/dfswt_gen.sv
`default_nettype none
// ============================================================================
//  Module      : dfswt_gen
//  Description : Square-wave excitation generator. Emits frames*POINTS
//                samples of +/-amplitude (or runs until stop when frames=0)
//                over a valid/ready stream, sign chosen by the MSB of a phase
//                counter that advances by step per accepted sample.
//  Ports       : clock, reset (async active-low), start, stop, step, frames,
//                amplitude, ready -> dataout, valid, last, busy, done.
//  Revision    : 1.0 - initial release
// ============================================================================
module dfswt_gen
  import dfswt_pkg::*;
#(
  parameter int POINTS    = 8,
  parameter int COUNTBITS = 3,
  parameter int FRAMEBITS = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic [COUNTBITS-1:0]       step,
  input  logic [FRAMEBITS-1:0]       frames,
  input  logic signed [SAMPLE_W-1:0] amplitude,
  input  logic                       ready,
  output logic signed [SAMPLE_W-1:0] dataout,
  output logic                       valid,
  output logic                       last,
  output logic                       busy,
  output logic                       done
);

  localparam int CNTW = FRAMEBITS + COUNTBITS;

  dfswt_gen_state_t            state_q,   state_d;
  logic [COUNTBITS-1:0]        step_q,    step_d;
  logic [FRAMEBITS-1:0]        frames_q,  frames_d;
  logic signed [SAMPLE_W-1:0]  amp_q,     amp_d;
  logic [CNTW-1:0]             cnt_q,     cnt_d;
  logic signed [SAMPLE_W-1:0]  dataout_q, dataout_d;
  logic                        valid_q,   valid_d;
  logic                        last_q,    last_d;
  logic                        done_q,    done_d;

  logic                        handshake;
  logic                        load;
  logic                        advance;
  logic                        finish;
  logic                        msb;
  logic                        msb_next;
  logic signed [SAMPLE_W-1:0]  amp_src;
  logic signed [SAMPLE_W-1:0]  amp_neg;

  // Index of the last sample of a counted burst is frames*POINTS-1.
  function automatic logic is_final(input logic [CNTW-1:0]      cnt,
                                    input logic [FRAMEBITS-1:0] fr);
    is_final = (fr != '0) && (cnt == ({fr, {COUNTBITS{1'b0}}} - CNTW'(1)));
  endfunction

  // Control strobes are kept outside the next-state block so the counter's
  // look-ahead MSB does not form a combinational loop through it.
  assign handshake = valid_q & ready;
  assign load      = (state_q == ST_IDLE) & start;
  assign advance   = (state_q == ST_RUN) & handshake;
  assign finish    = (state_q == ST_RUN) & (stop | (handshake & last_q));

  // On the start cycle the amplitude register is not yet loaded.
  assign amp_src = (state_q == ST_IDLE) ? amplitude : amp_q;
  assign amp_neg = sat_neg(amp_src);

  dfswt_phase_counter #(
    .POINTS    (POINTS),
    .COUNTBITS (COUNTBITS)
  ) u_phase (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .enable   (advance),
    .step     (step_q),
    .msb      (msb),
    .msb_next (msb_next)
  );

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    frames_d  = frames_q;
    amp_d     = amp_q;
    cnt_d     = cnt_q;
    dataout_d = dataout_q;
    valid_d   = valid_q;
    last_d    = last_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          step_d    = step;
          frames_d  = frames;
          amp_d     = amplitude;
          cnt_d     = '0;
          valid_d   = 1'b1;
          dataout_d = msb_next ? amp_neg : amp_src;
          last_d    = is_final('0, frames);
        end
      end
      ST_RUN: begin
        // Without a handshake the sample regenerates from the held phase.
        dataout_d = msb ? amp_neg : amp_src;
        if (finish) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
        end else if (handshake) begin
          // Continuous mode freezes the sample counter.
          if (frames_q != '0) begin
            cnt_d = cnt_q + CNTW'(1);
          end
          dataout_d = msb_next ? amp_neg : amp_src;
          last_d    = is_final(cnt_d, frames_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      frames_q  <= '0;
      amp_q     <= '0;
      cnt_q     <= '0;
      dataout_q <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      frames_q  <= frames_d;
      amp_q     <= amp_d;
      cnt_q     <= cnt_d;
      dataout_q <= dataout_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      done_q    <= done_d;
    end
  end

  assign dataout = dataout_q;
  assign valid   = valid_q;
  assign last    = last_q;
  assign busy    = (state_q == ST_RUN);
  assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_dfswt_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dfswt_gen
//  Description : Directed self-checking bench for dfswt_gen (POINTS=8).
//                Inputs change and outputs are sampled on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dfswt_gen;
  import dfswt_pkg::*;

  logic                       clock;
  logic                       reset;
  logic                       start;
  logic                       stop;
  logic [2:0]                 step;
  logic [7:0]                 frames;
  logic signed [SAMPLE_W-1:0] amplitude;
  logic                       ready;
  logic signed [SAMPLE_W-1:0] dataout;
  logic                       valid;
  logic                       last;
  logic                       busy;
  logic                       done;

  int total = 0;
  int bad   = 0;
  int xfer  = 0;
  logic signed [ACC_W-1:0] acc;

  // Hand-computed sample patterns, indexed by transfer number mod 8.
  int pat_s1  [8];
  int pat_s2  [8];
  int pat_sat [8];

  dfswt_gen #(
    .POINTS    (8),
    .COUNTBITS (3),
    .FRAMEBITS (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .step      (step),
    .frames    (frames),
    .amplitude (amplitude),
    .ready     (ready),
    .dataout   (dataout),
    .valid     (valid),
    .last      (last),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic start_burst(input logic [2:0] s, input logic [7:0] f,
                             input int a);
    step      = s;
    frames    = f;
    amplitude = SAMPLE_W'(a);
    start     = 1'b1;
    @(negedge clock);
    start     = 1'b0;
  endtask

  // Consume n samples of a counted burst, then check the end-of-burst cycle.
  // A step=1 correlator stage model accumulates the stream into acc.
  task automatic collect(input int n, input int pat[8], input bit bp);
    int k = 0;
    int cyc = 0;
    bit hold_chk = 1'b0;
    logic signed [SAMPLE_W-1:0] held_d;
    logic held_l;
    logic [2:0] sphase = 3'd2;
    logic r;
    acc = '0;
    while (k < n && cyc < 400) begin
      check("b_valid", valid, 1);
      if (hold_chk) begin
        check("b_hold_data", dataout, held_d);
        check("b_hold_last", last, held_l);
      end
      r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      ready = r;
      if (valid && r) begin
        check("b_data", dataout, pat[k % 8]);
        check("b_last", last, (k == n - 1) ? 1 : 0);
        check("b_busy", busy, 1);
        check("b_done", done, 0);
        acc = sphase[2] ? acc - ACC_W'(dataout) : acc + ACC_W'(dataout);
        sphase = sphase + 3'd1;
        k++;
        hold_chk = 1'b0;
      end else if (valid) begin
        held_d   = dataout;
        held_l   = last;
        hold_chk = 1'b1;
      end
      @(negedge clock);
      cyc++;
    end
    ready = 1'b1;
    if (k < n) check("b_timeout", k, n);
    check("e_valid", valid, 0);
    check("e_busy", busy, 0);
    check("e_done", done, 1);
  endtask

  // Continuous mode: take n samples with ready high; optionally pulse start
  // (with different parameters) before transfer index poke.
  task automatic run_cont(input int n, input int poke);
    int k = 0;
    int cyc = 0;
    while (k < n && cyc < 100) begin
      start = (k == poke);
      if (k == poke) begin
        amplitude = -16'sd5;
        step      = 3'd3;
        frames    = 8'd1;
      end
      if (valid && ready) begin
        check("c_data", dataout, pat_s1[xfer % 8]);
        check("c_last", last, 0);
        check("c_busy", busy, 1);
        xfer++;
        k++;
      end
      @(negedge clock);
      cyc++;
    end
    start     = 1'b0;
    amplitude = 16'sd100;
    step      = 3'd1;
    frames    = 8'd0;
    if (k < n) check("c_timeout", k, n);
  endtask

  task automatic cont_stop(input logic rdy);
    xfer = 0;
    start_burst(3'd1, 8'd0, 100);
    run_cont(5, -1);
    stop  = 1'b1;
    ready = rdy;
    if (valid && ready) begin
      check("s_data", dataout, pat_s1[xfer % 8]);
      xfer++;
    end
    @(negedge clock);
    stop  = 1'b0;
    ready = 1'b1;
    check("s_valid", valid, 0);
    check("s_done", done, 1);
    check("s_busy", busy, 0);
    @(negedge clock);
    check("s_done_once", done, 0);
    check("s_valid_idle", valid, 0);
  endtask

  initial begin
    pat_s1  = '{100, 100, -100, -100, -100, -100, 100, 100};
    pat_s2  = '{100, -100, -100, 100, 100, -100, -100, 100};
    pat_sat = '{-32768, -32768, 32767, 32767, 32767, 32767, -32768, -32768};

    reset = 1'b0; start = 1'b0; stop = 1'b0; step = '0; frames = '0;
    amplitude = '0; ready = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_data", dataout, 0);
    check("rst_valid", valid, 0);
    check("rst_last", last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b1;
    @(negedge clock);

    // Single frame, step 1.
    start_burst(3'd1, 8'd1, 100);
    collect(8, pat_s1, 1'b0);
    // New start in the same cycle as done; step 2, two frames.
    start_burst(3'd2, 8'd2, 100);
    collect(16, pat_s2, 1'b0);
    // Four frames into a step=1 stage: every product is +100.
    start_burst(3'd1, 8'd4, 100);
    collect(32, pat_s1, 1'b0);
    check("acc_step1", acc, 3200);
    // Random back-pressure: same sequence, stable while stalled.
    start_burst(3'd1, 8'd2, 100);
    collect(16, pat_s1, 1'b1);
    // Most-negative amplitude: negative half saturates.
    start_burst(3'd1, 8'd1, -32768);
    collect(8, pat_sat, 1'b0);
    @(negedge clock);
    check("done_one_cycle", done, 0);

    // Continuous mode with stop, ready low then high in the stop cycle.
    cont_stop(1'b0);
    cont_stop(1'b1);

    // start during RUN must not disturb the burst.
    xfer = 0;
    start_burst(3'd1, 8'd0, 100);
    run_cont(10, 3);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    check("r_done", done, 1);
    @(negedge clock);

    // Asynchronous reset mid-burst.
    xfer = 0;
    start_burst(3'd1, 8'd0, 100);
    run_cont(3, -1);
    #2 reset = 1'b0;
    #1;
    check("ar_valid", valid, 0);
    check("ar_busy", busy, 0);
    check("ar_data", dataout, 0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("ar_no_done", done, 0);
      check("ar_idle", valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
